hash_serializer: RTL and testbench



---
 rtl/hash_serializer_if.sv | 23 ++
 rtl/hash_serializer.sv | 71 +++++++
 tb/tb_hash_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hash_serializer_if.sv
// rtl/hash_serializer_if.sv - digest load and byte stream signals of hash_serializer
interface hash_serializer_if #(
  parameter int HASH_W = 256
);
  logic              hash_v_i;
  logic [HASH_W-1:0] hash_i;
  logic              data_ready_i;
  logic              data_v_o;
  logic [7:0]        data_o;
  logic              last_o;
  logic              busy_o;
  logic              ovf_o;

  modport master (
    output hash_v_i, hash_i, data_ready_i,
    input  data_v_o, data_o, last_o, busy_o, ovf_o
  );

  modport slave (
    input  hash_v_i, hash_i, data_ready_i,
    output data_v_o, data_o, last_o, busy_o, ovf_o
  );
endinterface

// File: rtl/hash_serializer.sv
// rtl/hash_serializer.sv - captures one digest and streams it out MSB byte first
module hash_serializer #(
  parameter int HASH_W = 256
) (
  input  logic           clk,
  input  logic           nreset,
  hash_serializer_if.slave bus
);
  localparam int NBYTES = HASH_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        state;
  logic [HASH_W-1:0] shreg;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic sending;
  logic at_last;
  logic xfer;

  assign sending = (state == ST_SEND);
  assign at_last = (count == CNT_W'(NBYTES - 1));
  assign xfer    = sending && bus.data_ready_i;

  // Outputs depend only on registered state, never directly on inputs.
  assign bus.data_v_o = sending;
  assign bus.busy_o   = sending;
  assign bus.data_o   = sending ? shreg[HASH_W-1 -: 8] : 8'h00;
  assign bus.last_o   = sending && at_last;
  assign bus.ovf_o    = ovf;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
      shreg <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.hash_v_i) begin
            shreg <= bus.hash_i;
            count <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer && at_last) begin
            // A digest arriving with the final transfer is chained with no bubble.
            if (bus.hash_v_i) begin
              shreg <= bus.hash_i;
              count <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            if (xfer) begin
              shreg <= {shreg[HASH_W-9:0], 8'h00};
              count <= count + 1'b1;
            end
            if (bus.hash_v_i) ovf <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_serializer.sv
// tb/tb_hash_serializer.sv - randomized self-checking bench for hash_serializer
module tb_hash_serializer;
  localparam int HASH_W = 256;
  localparam int NBYTES = HASH_W / 8;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  hash_serializer_if #(.HASH_W(HASH_W)) bus ();

  hash_serializer #(.HASH_W(HASH_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the bytes still owed to the consumer, front = on the pins now.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  always @(negedge clk) begin
    if (!nreset) begin
      chk("rst_v",    bus.data_v_o, 0);
      chk("rst_data", bus.data_o,   0);
      chk("rst_last", bus.last_o,   0);
      chk("rst_busy", bus.busy_o,   0);
      chk("rst_ovf",  bus.ovf_o,    0);
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      chk("m_v",    bus.data_v_o, mq.size() != 0);
      chk("m_data", bus.data_o,   (mq.size() != 0) ? mq[0] : 8'h00);
      chk("m_last", bus.last_o,   mq.size() == 1);
      chk("m_busy", bus.busy_o,   mq.size() != 0);
      chk("m_ovf",  bus.ovf_o,    m_ovf);
      if (mq.size() != 0 && bus.data_ready_i) void'(mq.pop_front());
      if (bus.hash_v_i) begin
        if (mq.size() == 0) begin
          for (int i = NBYTES - 1; i >= 0; i--) mq.push_back(bus.hash_i[8*i +: 8]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [HASH_W-1:0] h);
    bus.hash_i   = h;
    bus.hash_v_i = 1'b1;
    cyc();
    bus.hash_v_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (bus.busy_o && n < limit) begin
      cyc();
      n++;
    end
    chk("drain_done", bus.busy_o, 0);
  endtask

  logic [HASH_W-1:0] d1, d2, d3, dr;
  int               n, cycles;
  logic             prev_v, prev_r;
  logic [7:0]       prev_d;

  initial begin
    bus.hash_v_i     = 1'b0;
    bus.hash_i       = '0;
    bus.data_ready_i = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      d1[HASH_W-1-8*i -: 8] = 8'(i);
      d2[HASH_W-1-8*i -: 8] = 8'(8'hFF - i);
    end
    d3 = {NBYTES{8'hAA}};

    repeat (3) cyc();
    chk("reset_v", bus.data_v_o, 0);
    chk("reset_ovf", bus.ovf_o, 0);
    nreset = 1'b1;

    // Idle robustness
    bus.data_ready_i = 1'b1;
    repeat (100) cyc();
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_data", bus.data_o, 8'h00);

    // Basic stream
    strobe(d1);
    chk("first_valid", bus.data_v_o, 1);
    chk("first_byte", bus.data_o, 8'h00);
    n = 0;
    while (bus.data_v_o && n < 40) begin
      chk("basic_byte", bus.data_o, n);
      chk("basic_last", bus.last_o, n == NBYTES - 1);
      n++;
      cyc();
    end
    chk("basic_count", n, NBYTES);
    chk("basic_end_v", bus.data_v_o, 0);
    chk("basic_end_busy", bus.busy_o, 0);

    // Backpressure
    bus.data_ready_i = 1'b0;
    strobe(d1);
    n = 0;
    cycles = 0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = 8'h00;
    while (bus.busy_o && cycles < 400) begin
      if (prev_v && !prev_r) chk("bp_stable", bus.data_o, prev_d);
      bus.data_ready_i = 1'($urandom_range(0, 1));
      if (bus.data_v_o && bus.data_ready_i) begin
        chk("bp_byte", bus.data_o, n);
        n++;
      end
      prev_v = bus.data_v_o;
      prev_r = bus.data_ready_i;
      prev_d = bus.data_o;
      cycles++;
      cyc();
    end
    chk("bp_count", n, NBYTES);

    // Back-to-back
    bus.data_ready_i = 1'b1;
    strobe(d1);
    cycles = 0;
    while (!bus.last_o && cycles < 40) begin
      cyc();
      cycles++;
    end
    chk("b2b_at_last", bus.data_o, 8'h1F);
    bus.hash_i   = d2;
    bus.hash_v_i = 1'b1;
    cyc();
    bus.hash_v_i = 1'b0;
    chk("b2b_valid", bus.data_v_o, 1);
    chk("b2b_byte", bus.data_o, 8'hFF);
    chk("b2b_ovf", bus.ovf_o, 0);
    drain(60);

    // Dropped digest while byte 5 is transferred
    strobe(d1);
    repeat (5) cyc();
    chk("drop_pre", bus.data_o, 8'h05);
    bus.hash_i   = d3;
    bus.hash_v_i = 1'b1;
    cyc();
    bus.hash_v_i = 1'b0;
    chk("drop_next", bus.data_o, 8'h06);
    chk("drop_ovf", bus.ovf_o, 1);
    drain(60);
    repeat (5) cyc();
    chk("drop_sticky", bus.ovf_o, 1);

    // Reset mid-stream
    strobe(d1);
    repeat (10) cyc();
    chk("rst_mid_pre", bus.data_o, 8'h0A);
    #2 nreset = 1'b0;
    #1;
    chk("rst_mid_v", bus.data_v_o, 0);
    chk("rst_mid_data", bus.data_o, 0);
    chk("rst_mid_busy", bus.busy_o, 0);
    chk("rst_mid_ovf", bus.ovf_o, 0);
    cyc();
    nreset = 1'b1;
    repeat (10) begin
      chk("post_rst_v", bus.data_v_o, 0);
      cyc();
    end

    // Random traffic
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < HASH_W / 32; w++) dr[32*w +: 32] = $urandom;
      repeat ($urandom_range(0, 4)) cyc();
      bus.data_ready_i = 1'($urandom_range(0, 1));
      strobe(dr);
      cycles = 0;
      while (bus.busy_o && cycles < 300) begin
        bus.data_ready_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) begin
          for (int w = 0; w < HASH_W / 32; w++) bus.hash_i[32*w +: 32] = $urandom;
          bus.hash_v_i = 1'b1;
        end
        cyc();
        bus.hash_v_i = 1'b0;
        cycles++;
      end
      chk("rand_done", bus.busy_o, 0);
    end

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
